// File: rtl/clkgen_pkg.sv
// ---------------------------------------------------------------------------
// clkgen_pkg
// Shared types and constants for the clkgen_pwm_div programmable divider.
//   state_e    : divider FSM states (IDLE, RUN, DRAIN)
//   CNT_W_DEF  : default width of the period/high-time counters
//   MIN_PERIOD : smallest period that can actually toggle
// ---------------------------------------------------------------------------
package clkgen_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/clkgen_cfg_shadow.sv
// ---------------------------------------------------------------------------
// clkgen_cfg_shadow
// Shadow (pending) registers for the divider configuration. A legal
// cfg_load captures period/high-time and raises the pending flag; an illegal
// one (period < MIN_PERIOD) leaves everything untouched and pulses cfg_err
// one cycle later. The owner of the active settings clears the pending flag
// through apply_take when it copies the pending values.
// Ports:
//   clk, rst              : system clock, synchronous active-high reset
//   cfg_load              : one-cycle capture strobe
//   cfg_period, cfg_high  : requested period / high-time
//   apply_take            : pending values are being consumed this cycle
//   pend_valid            : a pending configuration is waiting (apply-ready)
//   pend_period, pend_high: pending values
//   cfg_err               : one-cycle rejection pulse
// ---------------------------------------------------------------------------
module clkgen_cfg_shadow
  import clkgen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             apply_take,
  output logic             pend_valid,
  output logic [CNT_W-1:0] pend_period,
  output logic [CNT_W-1:0] pend_high,
  output logic             cfg_err
);

  logic             pend_valid_q, pend_valid_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic             cfg_err_q, cfg_err_d;
  logic             load_ok;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load_ok       = cfg_load && (cfg_period >= CNT_W'(MIN_PERIOD));
    pend_valid_d  = pend_valid_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    cfg_err_d     = cfg_load && !load_ok;
    // A load in the same cycle as a take wins: the old value is consumed now,
    // the new one stays pending for the next apply point.
    if (load_ok) begin
      pend_valid_d  = 1'b1;
      pend_period_d = cfg_period;
      pend_high_d   = cfg_high;
    end else if (apply_take) begin
      pend_valid_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q  <= 1'b0;
      pend_period_q <= '0;
      pend_high_q   <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign pend_valid  = pend_valid_q;
  assign pend_period = pend_period_q;
  assign pend_high   = pend_high_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: rtl/clkgen_pwm_div.sv
// ---------------------------------------------------------------------------
// clkgen_pwm_div
// Programmable clock divider with programmable high-time. A counter runs
// 0..P-1 and clk_out is registered as (cnt < H), so each period is H cycles
// high then P-H low. New settings are held in clkgen_cfg_shadow and only
// become active at a period wrap (or immediately while idle), so clk_out
// never glitches. Dropping en lets the current period finish (DRAIN).
// Optional feature macro: CLKGEN_EDGE_PULSE_EN adds rise_pulse/fall_pulse,
// one-cycle strobes coincident with the cycle clk_out goes high/low.
// Ports:
//   clk, rst              : system clock, synchronous active-high reset
//   en                    : run request (level)
//   cfg_period, cfg_high  : requested period / high-time, cfg_load strobe
//   cfg_ack               : pending config became active (one cycle)
//   cfg_err               : cfg_load rejected, period < 2 (one cycle)
//   busy                  : in RUN or DRAIN
//   clk_out               : divided clock, registered
// ---------------------------------------------------------------------------
module clkgen_pwm_div
  import clkgen_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int RST_PERIOD = 2,
  parameter int RST_HIGH   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_load,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             busy,
  output logic             clk_out
`ifdef CLKGEN_EDGE_PULSE_EN
  ,
  output logic             rise_pulse,
  output logic             fall_pulse
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             clk_out_q, clk_out_d;
  logic             cfg_ack_q, cfg_ack_d;
  logic             wrap;
  logic             apply;
  logic             pend_valid;
  logic [CNT_W-1:0] pend_period;
  logic [CNT_W-1:0] pend_high;

  clkgen_cfg_shadow #(.CNT_W(CNT_W)) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .apply_take (apply),
    .pend_valid (pend_valid),
    .pend_period(pend_period),
    .pend_high  (pend_high),
    .cfg_err    (cfg_err)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clk_out_d = 1'b0;
    // >= rather than == keeps the counter bounded even if P shrank under it.
    wrap      = (cnt_q >= per_q - CNT_W'(1));
    apply     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        apply = pend_valid;
        if (en) state_d = RUN;
      end
      RUN, DRAIN: begin
        // clk_out lags the counter by one cycle: it reflects the count held now.
        clk_out_d = (cnt_q < high_q);
        if (wrap) begin
          cnt_d   = '0;
          apply   = pend_valid;
          state_d = en ? RUN : IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = en ? RUN : DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    per_d     = apply ? pend_period : per_q;
    high_d    = apply ? pend_high   : high_q;
    cfg_ack_d = apply;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      per_q     <= CNT_W'(RST_PERIOD);
      high_q    <= CNT_W'(RST_HIGH);
      clk_out_q <= 1'b0;
      cfg_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      high_q    <= high_d;
      clk_out_q <= clk_out_d;
      cfg_ack_q <= cfg_ack_d;
    end
  end

  assign clk_out = clk_out_q;
  assign cfg_ack = cfg_ack_q;
  assign busy    = (state_q != IDLE);

`ifdef CLKGEN_EDGE_PULSE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Computed from the next clk_out value so the strobe lands in the same
  // cycle the registered clk_out changes.
  always_comb begin
    rise_d = clk_out_d & ~clk_out_q;
    fall_d = ~clk_out_d & clk_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`endif

endmodule

// File: doc/clkgen_pwm_div.md
# clkgen_pwm_div

Synthesizable programmable clock divider that derives a divided clock of any integer period and programmable high-time (duty cycle) from one system clock. It is the hardware source for the 1 MHz/2 MHz, 40/50/70 % duty-cycle clocks that the clock-stimulus benches model behaviourally. It sits directly downstream of the system clock and feeds the timing-stimulus consumers. New settings are shadowed and applied glitch-free only at a period boundary.

## Interface
- CNT_W, 8, width of period/high-time counters
- RST_PERIOD, 2, active period (cycles) after reset
- RST_HIGH, 1, active high-time (cycles) after reset

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run request; level-sensitive
- cfg_period  in  CNT_W  requested period in clk cycles; legal 2..2^CNT_W-1
- cfg_high  in  CNT_W  requested high-time in clk cycles
- cfg_load  in  1  one-cycle strobe: capture cfg_period/cfg_high
- cfg_ack  out  1  one-cycle pulse: pending config became active
- cfg_err  out  1  one-cycle pulse: cfg_load rejected (period < 2)
- busy  out  1  high in RUN or DRAIN
- clk_out  out  1  divided clock, registered, glitch-free

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: cnt=0, clk_out=0. en=1 -> RUN, with cnt=0 for the first cycle of the period.
- RUN: cnt counts 0..P-1, then wraps to 0. clk_out = (cnt < H), registered.
- en=0 seen in RUN -> DRAIN. The current period completes. At the wrap -> IDLE.
- en=1 seen in DRAIN -> RUN. The period continues with no gap.
- H=0 gives constant low. H>=P gives constant high. Both are legal and not errors.
- cfg_load with cfg_period<2: cfg_err pulses the next cycle. Pending and active settings are unchanged.
- cfg_load with a legal period: the value is captured into the pending registers and the pending flag is set.
- Pending config is applied:
  - in RUN/DRAIN: at the wrap cycle, with the new P/H governing the period that starts then;
  - in IDLE: on the next cycle.
- cfg_ack pulses in the cycle the config is applied.
- Second cfg_load while pending: the later value overwrites the earlier one. Only one cfg_ack is issued.
- cfg_load coincident with the wrap: the newly loaded value is applied at the following wrap. The old pending value, if any, is applied now and acked.
- Period/high arithmetic is unsigned CNT_W-bit. The counter never exceeds P-1.

## Timing
- Reset values:
  - clk_out=0, cfg_ack=0, cfg_err=0, busy=0
  - state=IDLE, cnt=0, pending=0
  - active P=RST_PERIOD, H=RST_HIGH
- en sampled high at edge t -> busy=1 and clk_out=(H>0) after edge t+1.
- Each RUN period is exactly P cycles: H cycles high, then P-H cycles low.
- cfg_err is asserted 1 cycle after the offending cfg_load.
- rst during RUN/DRAIN aborts immediately: clk_out=0 on the next cycle, and pending config is discarded.

## Configuration
- CLKGEN_EDGE_PULSE_EN defined: adds outputs rise_pulse and fall_pulse (1 bit each, reset 0).
  - Each pulses for one cycle, aligned with the cycle in which clk_out changes 0->1 or 1->0.
  - Usable as clock enables by downstream logic.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package clkgen_pkg holds:
  - state enum (IDLE, RUN, DRAIN)
  - default CNT_W constant
  - MIN_PERIOD=2 constant
- Sub-module clkgen_cfg_shadow holds the pending registers, validation, the pending flag and cfg_err generation.
  - Its outputs are apply-ready and pending values.
  - The top module owns the FSM, counter and clk_out.

## Test plan
- Reset, en=1, defaults (P=2, H=1) -> clk_out toggles every cycle, 50 % duty, first high 1 cycle after en.
- cfg_load P=10, H=7 while IDLE, then en=1 -> cfg_ack next cycle; clk_out 7 high / 3 low repeating (1 MHz 70 % from 10 MHz).
- Running P=10, H=7; mid-period cfg_load P=5, H=2 -> current period finishes 7/3; cfg_ack at the wrap; then 2 high / 3 low.
- cfg_load P=1 -> cfg_err pulse one cycle later, no cfg_ack, output unchanged. Also H=0 gives constant 0, and H=12 with P=10 gives constant 1.
- en dropped at cnt=3 of P=10, H=4 -> clk_out finishes the period (cnt 3 high, 4..9 low), busy falls at the wrap, clk_out stays 0.
- rst asserted mid-high with a pending config -> next cycle clk_out=0, busy=0, active P=2/H=1, no cfg_ack ever issued.
